pc_fetch_unit: RTL and testbench

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

---
 rtl/pc_fetch_unit.sv | 148 ++++++++++++++
 tb/tb_pc_fetch_unit.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// Instruction fetch front end: one outstanding memory request, a one-entry output buffer,
// and prioritised redirects (exception > eret > branch) with stale-response cancellation.
module pc_fetch_unit #(
  parameter int unsigned    N        = 32,
  parameter logic [N-1:0]   RESET_PC = N'(32'hBFC00000),
  parameter logic [N-1:0]   EXC_VEC  = N'(32'hBFC00380)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stall,
  input  logic         flush_except,
  input  logic         eret,
  input  logic [N-1:0] epc,
  input  logic         br_taken,
  input  logic [N-1:0] br_target,
  output logic         req,
  output logic [N-1:0] req_addr,
  input  logic         addr_ok,
  input  logic         data_ok,
  input  logic [N-1:0] rdata,
  output logic         inst_valid,
  output logic [N-1:0] inst,
  output logic [N-1:0] inst_pc,
  output logic         adel
);

  typedef enum logic [0:0] {StReq, StWait} state_e;

  state_e       state_q, state_d;
  logic [N-1:0] pc_q, pc_d;
  logic [N-1:0] inflight_pc_q, inflight_pc_d;
  logic [N-1:0] inst_q, inst_d;
  logic [N-1:0] inst_pc_q, inst_pc_d;
  logic         cancel_q, cancel_d;
  logic         inst_valid_q, inst_valid_d;
  logic         adel_q, adel_d;
  logic         halt_q, halt_d;

  logic         redirect;
  logic [N-1:0] redirect_pc;
  logic         buf_free;

  always_comb begin
    redirect    = flush_except | eret | br_taken;
    redirect_pc = br_target;
    if (flush_except) begin
      redirect_pc = EXC_VEC;
    end else if (eret) begin
      redirect_pc = epc;
    end
  end

  assign buf_free = !inst_valid_q || !stall;
  assign req      = rst && (state_q == StReq) && (pc_q[1:0] == 2'b00) && !redirect && buf_free;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    inflight_pc_d = inflight_pc_q;
    inst_d        = inst_q;
    inst_pc_d     = inst_pc_q;
    cancel_d      = cancel_q;
    inst_valid_d  = inst_valid_q;
    adel_d        = adel_q;
    halt_d        = halt_q;

    if (inst_valid_q && !stall) begin
      inst_valid_d = 1'b0;
    end

    if (redirect) begin
      pc_d         = redirect_pc;
      inst_valid_d = 1'b0;
      halt_d       = 1'b0;
      if (state_q == StWait) begin
        // A response arriving with the redirect is dropped directly; otherwise drop the next one.
        if (data_ok) begin
          state_d  = StReq;
          cancel_d = 1'b0;
        end else begin
          cancel_d = 1'b1;
        end
      end
    end else begin
      unique case (state_q)
        StReq: begin
          if (req && addr_ok) begin
            inflight_pc_d = pc_q;
            pc_d          = pc_q + N'(4);
            state_d       = StWait;
          end else if (rst && (pc_q[1:0] != 2'b00) && buf_free && !halt_q) begin
            // Misaligned pc: emit a single address-error entry, then idle until redirected.
            inst_d       = '0;
            inst_pc_d    = pc_q;
            adel_d       = 1'b1;
            inst_valid_d = 1'b1;
            halt_d       = 1'b1;
          end
        end
        StWait: begin
          if (data_ok) begin
            state_d = StReq;
            if (cancel_q) begin
              cancel_d = 1'b0;
            end else begin
              inst_d       = rdata;
              inst_pc_d    = inflight_pc_q;
              adel_d       = 1'b0;
              inst_valid_d = 1'b1;
            end
          end
        end
        default: state_d = StReq;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StReq;
      pc_q          <= RESET_PC;
      inflight_pc_q <= '0;
      inst_q        <= '0;
      inst_pc_q     <= '0;
      cancel_q      <= 1'b0;
      inst_valid_q  <= 1'b0;
      adel_q        <= 1'b0;
      halt_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inflight_pc_q <= inflight_pc_d;
      inst_q        <= inst_d;
      inst_pc_q     <= inst_pc_d;
      cancel_q      <= cancel_d;
      inst_valid_q  <= inst_valid_d;
      adel_q        <= adel_d;
      halt_q        <= halt_d;
    end
  end

  assign req_addr   = pc_q;
  assign inst_valid = inst_valid_q;
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;
  assign adel       = adel_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed and random checks of pc_fetch_unit against a transaction-queue reference model.
module tb_pc_fetch_unit;

  localparam logic [31:0] ResetPc = 32'hBFC00000;
  localparam logic [31:0] ExcVec  = 32'hBFC00380;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, flush_except, eret, br_taken, addr_ok, data_ok;
  logic [31:0] epc, br_target, rdata;
  logic        req, inst_valid, adel;
  logic [31:0] req_addr, inst, inst_pc;

  pc_fetch_unit dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .flush_except (flush_except),
    .eret         (eret),
    .epc          (epc),
    .br_taken     (br_taken),
    .br_target    (br_target),
    .req          (req),
    .req_addr     (req_addr),
    .addr_ok      (addr_ok),
    .data_ok      (data_ok),
    .rdata        (rdata),
    .inst_valid   (inst_valid),
    .inst         (inst),
    .inst_pc      (inst_pc),
    .adel         (adel)
  );

  always #5 clk = ~clk;

  // Reference model: outstanding requests as a queue, each tagged with whether it was redirected away.
  typedef struct packed {
    logic [31:0] pc;
    logic        drop;
  } txn_t;

  txn_t        q[$];
  logic [31:0] m_pc, m_inst, m_inst_pc;
  logic        m_valid, m_adel, m_halt;

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic model_reset();
    q.delete();
    m_pc      = ResetPc;
    m_valid   = 1'b0;
    m_inst    = '0;
    m_inst_pc = '0;
    m_adel    = 1'b0;
    m_halt    = 1'b0;
  endtask

  function automatic logic model_req();
    return rst && (q.size() == 0) && (m_pc[1:0] == 2'b00) && !(flush_except | eret | br_taken)
           && (!m_valid || !stall);
  endfunction

  task automatic model_edge();
    logic        redir, free, exp_req;
    logic [31:0] tgt;
    txn_t        t;
    if (!rst) begin
      model_reset();
      return;
    end
    redir   = flush_except | eret | br_taken;
    tgt     = flush_except ? ExcVec : (eret ? epc : br_target);
    free    = !m_valid || !stall;
    exp_req = model_req();
    if (m_valid && !stall) m_valid = 1'b0;
    if (data_ok && q.size() > 0) begin
      t = q.pop_front();
      if (!t.drop && !redir) begin
        m_inst = rdata; m_inst_pc = t.pc; m_adel = 1'b0; m_valid = 1'b1;
      end
    end
    if (redir) begin
      foreach (q[i]) q[i].drop = 1'b1;
      m_pc = tgt; m_valid = 1'b0; m_halt = 1'b0;
    end else if (exp_req && addr_ok) begin
      q.push_back('{pc: m_pc, drop: 1'b0});
      m_pc = m_pc + 32'd4;
    end else if (q.size() == 0 && m_pc[1:0] != 2'b00 && free && !m_halt) begin
      m_inst = '0; m_inst_pc = m_pc; m_adel = 1'b1; m_valid = 1'b1; m_halt = 1'b1;
    end
  endtask

  // Called at a negedge with inputs driven: compare against the model, then advance one edge.
  task automatic step(input string tag);
    #1;
    chk({tag, ".req"}, 32'(req), 32'(model_req()));
    if (model_req()) chk({tag, ".req_addr"}, req_addr, m_pc);
    chk({tag, ".inst_valid"}, 32'(inst_valid), 32'(m_valid));
    if (m_valid) begin
      chk({tag, ".inst"}, inst, m_inst);
      chk({tag, ".inst_pc"}, inst_pc, m_inst_pc);
      chk({tag, ".adel"}, 32'(adel), 32'(m_adel));
    end
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    stall = 0; flush_except = 0; eret = 0; br_taken = 0; addr_ok = 0; data_ok = 0;
  endtask

  initial begin
    rst = 1'b0; idle_inputs();
    epc = '0; br_target = '0; rdata = '0;
    model_reset();
    @(negedge clk);
    #1;
    chk("reset.req", 32'(req), 32'd0);
    chk("reset.inst_valid", 32'(inst_valid), 32'd0);
    chk("reset.inst", inst, 32'd0);
    chk("reset.inst_pc", inst_pc, 32'd0);
    chk("reset.adel", 32'(adel), 32'd0);
    step("reset");

    // First fetch after reset release.
    rst = 1'b1;
    #1;
    chk("boot.req", 32'(req), 32'd1);
    chk("boot.req_addr", req_addr, ResetPc);
    addr_ok = 1; step("boot.accept");
    addr_ok = 0; data_ok = 1; rdata = 32'h24080001; step("boot.data");
    data_ok = 0; stall = 1;
    #1;
    chk("boot.inst_valid", 32'(inst_valid), 32'd1);
    chk("boot.inst", inst, 32'h24080001);
    chk("boot.inst_pc", inst_pc, ResetPc);
    chk("boot.next_addr", req_addr, 32'hBFC00004);

    // Stall holds the buffer and blocks new requests.
    addr_ok = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall.req", 32'(req), 32'd0);
      chk("stall.inst_pc", inst_pc, ResetPc);
      step("stall");
    end
    stall = 0;
    #1;
    chk("unstall.req", 32'(req), 32'd1);
    step("unstall.accept");

    // Branch while waiting: the pending response is discarded.
    addr_ok = 0; br_taken = 1; br_target = 32'h80001000; step("br.wait");
    br_taken = 0; data_ok = 1; rdata = 32'hDEADBEEF; step("br.drop");
    data_ok = 0;
    #1;
    chk("br.inst_valid", 32'(inst_valid), 32'd0);
    chk("br.req_addr", req_addr, 32'h80001000);
    chk("br.req", 32'(req), 32'd1);

    // Exception beats branch in the same cycle.
    flush_except = 1; br_taken = 1; br_target = 32'h80002000; step("prio");
    flush_except = 0; br_taken = 0;
    #1;
    chk("prio.req_addr", req_addr, ExcVec);

    // eret to a misaligned epc yields one address-error entry.
    eret = 1; epc = 32'h80000002; step("eret");
    eret = 0; step("eret.load");
    #1;
    chk("eret.req", 32'(req), 32'd0);
    chk("eret.inst_valid", 32'(inst_valid), 32'd1);
    chk("eret.adel", 32'(adel), 32'd1);
    chk("eret.inst_pc", inst_pc, 32'h80000002);
    for (int i = 0; i < 3; i++) step("eret.idle");

    // pc wraps past all-ones.
    br_taken = 1; br_target = 32'hFFFFFFFC; step("wrap.redir");
    br_taken = 0; addr_ok = 1; step("wrap.accept");
    addr_ok = 0; data_ok = 1; rdata = 32'h12345678; step("wrap.data");
    data_ok = 0;
    #1;
    chk("wrap.req_addr", req_addr, 32'h00000000);
    chk("wrap.inst_pc", inst_pc, 32'hFFFFFFFC);

    // Reset in the middle of a transaction; a late response must be ignored.
    step("mid.consume");
    addr_ok = 1; step("mid.accept");
    addr_ok = 0; rst = 0;
    #1;
    chk("mid.req", 32'(req), 32'd0);
    chk("mid.inst_valid", 32'(inst_valid), 32'd0);
    step("mid.reset");
    rst = 1; data_ok = 1; rdata = 32'hBADBAD00; step("mid.late");
    data_ok = 0;
    #1;
    chk("mid.req_addr", req_addr, ResetPc);
    chk("mid.no_inst", 32'(inst_valid), 32'd0);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      stall        = ($urandom_range(0, 2) == 0);
      addr_ok      = ($urandom_range(0, 2) != 0);
      data_ok      = ($urandom_range(0, 2) != 0);
      rdata        = $urandom;
      flush_except = ($urandom_range(0, 29) == 0);
      eret         = ($urandom_range(0, 19) == 0);
      br_taken     = ($urandom_range(0, 9) == 0);
      epc          = $urandom & (($urandom_range(0, 7) == 0) ? 32'hFFFFFFFF : 32'hFFFFFFFC);
      br_target    = $urandom & (($urandom_range(0, 7) == 0) ? 32'hFFFFFFFF : 32'hFFFFFFFC);
      step("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
